// File: rtl/booth_r4_ppgen_pkg.sv
// Shared multiplier definitions: operand/partial-product sizes, Booth digit
// selection codes and the radix-4 group decoder.
package booth_r4_ppgen_pkg;

  localparam int MUL_OPW = 16;
  localparam int MUL_NPP = 8;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_e;

  // grp = {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_sel_e booth_decode(input logic [2:0] grp);
    booth_sel_e sel;
    case (grp)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// One partial-product lane: picks 0/+A/+2A/-A/-2A and applies the lane's
// fixed left shift, truncated to WIDTH.
module booth_pp_sel
  import booth_r4_ppgen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 0
) (
  input  booth_sel_e       sel_i,
  input  logic [WIDTH-1:0] pos1_i,
  input  logic [WIDTH-1:0] pos2_i,
  input  logic [WIDTH-1:0] neg1_i,
  input  logic [WIDTH-1:0] neg2_i,
  output logic [WIDTH-1:0] pp_o
);

  logic [WIDTH-1:0] mux;

  always_comb begin
    mux = '0;
    case (sel_i)
      POS1:    mux = pos1_i;
      POS2:    mux = pos2_i;
      NEG1:    mux = neg1_i;
      NEG2:    mux = neg2_i;
      default: mux = '0;
    endcase
    pp_o = mux << SHIFT;
  end

endmodule

// File: rtl/booth_r4_ppgen.sv
// Radix-4 Booth partial-product generator, signed 16x16 -> eight 32-bit PPs.
// BOOTH_PPGEN_PIPE2_EN adds the operand stage (latency/capacity 2); else 1.
module booth_r4_ppgen
  import booth_r4_ppgen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MUL_OPW-1:0] in_a,
  input  logic [MUL_OPW-1:0] in_b,
  input  logic [TAGW-1:0]    in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_pp [MUL_NPP],
  output logic [TAGW-1:0]    out_tag
);

  if (WIDTH != 2 * MUL_OPW) begin : g_width_check
    $error("booth_r4_ppgen: WIDTH must be 32");
  end

  // Operand preparation; the +1 of negation is folded in here.
  logic [WIDTH-1:0]   a_ext, a_neg, a_x2, a_neg_x2;
  logic [MUL_OPW:0]   b_ext;
  logic [2:0]         grp_in [MUL_NPP];

  always_comb begin
    a_ext    = {{(WIDTH - MUL_OPW){in_a[MUL_OPW-1]}}, in_a};
    a_neg    = -a_ext;
    a_x2     = a_ext << 1;
    a_neg_x2 = -a_x2;
  end

  assign b_ext = {in_b, 1'b0};

  for (genvar gi = 0; gi < MUL_NPP; gi++) begin : g_grp
    assign grp_in[gi] = b_ext[2*gi +: 3];
  end

  logic             s2_valid_q, s2_valid_d;
  logic             s2_ready, s2_load;
  logic             src_valid;
  logic [WIDTH-1:0] src_a, src_an, src_a2, src_a2n;
  logic [2:0]       src_grp [MUL_NPP];
  logic [TAGW-1:0]  src_tag;

  assign s2_ready = !s2_valid_q || out_ready;

`ifdef BOOTH_PPGEN_PIPE2_EN
  logic             s1_valid_q, s1_valid_d;
  logic             s1_ready, s1_load;
  logic [WIDTH-1:0] s1_a_q, s1_an_q, s1_a2_q, s1_a2n_q;
  logic [2:0]       s1_grp_q [MUL_NPP];
  logic [TAGW-1:0]  s1_tag_q;

  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready && !flush;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)         s1_valid_d = 1'b0;
    else if (s1_ready) s1_valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_an_q    <= '0;
      s1_a2_q    <= '0;
      s1_a2n_q   <= '0;
      s1_tag_q   <= '0;
      for (int i = 0; i < MUL_NPP; i++) s1_grp_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_a_q   <= a_ext;
        s1_an_q  <= a_neg;
        s1_a2_q  <= a_x2;
        s1_a2n_q <= a_neg_x2;
        s1_tag_q <= in_tag;
        s1_grp_q <= grp_in;
      end
    end
  end

  assign src_valid = s1_valid_q;
  assign src_a     = s1_a_q;
  assign src_an    = s1_an_q;
  assign src_a2    = s1_a2_q;
  assign src_a2n   = s1_a2n_q;
  assign src_grp   = s1_grp_q;
  assign src_tag   = s1_tag_q;
`else
  assign in_ready  = s2_ready && !flush;
  assign src_valid = in_valid;
  assign src_a     = a_ext;
  assign src_an    = a_neg;
  assign src_a2    = a_x2;
  assign src_a2n   = a_neg_x2;
  assign src_grp   = grp_in;
  assign src_tag   = in_tag;
`endif

  // Data may load during a flush; only the valid bit is killed.
  assign s2_load = src_valid && s2_ready;

  booth_sel_e       sel    [MUL_NPP];
  logic [WIDTH-1:0] pp_sel [MUL_NPP];

  for (genvar gi = 0; gi < MUL_NPP; gi++) begin : g_lane
    assign sel[gi] = booth_decode(src_grp[gi]);

    booth_pp_sel #(
      .WIDTH(WIDTH),
      .SHIFT(2 * gi)
    ) u_pp_sel (
      .sel_i (sel[gi]),
      .pos1_i(src_a),
      .pos2_i(src_a2),
      .neg1_i(src_an),
      .neg2_i(src_a2n),
      .pp_o  (pp_sel[gi])
    );
  end

  logic [WIDTH-1:0] pp_q [MUL_NPP];
  logic [WIDTH-1:0] pp_d [MUL_NPP];
  logic [TAGW-1:0]  tag_q, tag_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    pp_d       = pp_q;
    tag_d      = tag_q;
    if (flush)         s2_valid_d = 1'b0;
    else if (s2_ready) s2_valid_d = src_valid;
    if (s2_load) begin
      pp_d  = pp_sel;
      tag_d = src_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      tag_q      <= '0;
      for (int i = 0; i < MUL_NPP; i++) pp_q[i] <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      tag_q      <= tag_d;
      pp_q       <= pp_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_pp    = pp_q;
  assign out_tag   = tag_q;

endmodule
